pix_rst_sequencer: RTL
======================

# pix_rst_sequencer

Pixel-domain reset sequencer that sits directly after the pixel-clock MMCM. It synchronises the MMCM `locked` flag into `clk_pix` with a parametrised synchroniser depth and holds all pixel-domain logic in reset until lock has been stable for a programmable time. It then releases `NUM_RST` reset channels in a staggered order, for example timing generator, then TMDS encoders, then SerDes. Any later loss of lock, or a software reset request, returns every channel to reset.

## Interface
- `NUM_RST`, 3: number of reset channels, 1–8.
- `HOLD_CYCLES`, 1024: stable-lock cycles required before the first release, ≥1.
- `STAGGER`, 16: cycles between successive channel releases, ≥1.
- `SYNC_STAGES`, 2: depth of the `locked_in` synchroniser, ≥2.
- `CNT_W`, 8: width of the lock-loss counter.

- `clk_pix`  in  1  pixel clock.
- `rst`  in  1  asynchronous, active-high reset.
- `locked_in`  in  1  MMCM lock flag; asynchronous to `clk_pix`.
- `soft_rst`  in  1  synchronous software reset request, active-high.
- `rst_out`  out  NUM_RST  per-channel resets, active-high, registered.
- `ready`  out  1  all channels released; registered.
- `state`  out  2  current FSM state.
- `lock_loss_cnt`  out  CNT_W  saturating count of lock-loss events.

## Operation
- **Reset values:** on `rst`, all synchroniser flops are 0, `rst_out` is all-ones, `ready` is 0, `state` is WAIT, the hold and stagger counters are 0, and `lock_loss_cnt` is 0.
- **Synchroniser:** `SYNC_STAGES` flops in series. `lk` is the last stage and is the only lock signal the FSM uses.
- **State encoding:** WAIT=0, HOLD=1, RELEASE=2, RUN=3.
- **WAIT:** `rst_out` all-ones, `ready` 0.
  - If `lk`=1 and `soft_rst`=0 at an edge: go to HOLD and clear the hold counter.
- **HOLD:** `rst_out` stays all-ones.
  - At each edge with `lk`=1: if hold counter = `HOLD_CYCLES`−1, go to RELEASE and clear channel index and stagger counter; otherwise increment the hold counter.
- **RELEASE:** `rst_out[k]` deasserts at edge T0 + k·`STAGGER`, where T0 is the HOLD→RELEASE edge.
  - At edge T0 + `NUM_RST`·`STAGGER`, go to RUN and set `ready`=1.
  - Channels are released in index order only. A released channel stays released until an abort.
- **RUN:** `rst_out` all-zeros, `ready` 1.
- **Abort:** in any state other than WAIT, if `lk`=0 or `soft_rst`=1 at an edge:
  - The FSM returns to WAIT.
  - `rst_out` goes all-ones and `ready` goes 0 on that same edge.
  - All internal counters clear.
- **Lock-loss count:** `lock_loss_cnt` increments on an edge where `lk`=0 and state is RELEASE or RUN.
  - It counts even when `soft_rst` is 1 in the same cycle.
  - Lock loss in HOLD is not counted.
  - `soft_rst` alone is never counted.
  - The counter saturates at 2^`CNT_W`−1 and does not wrap.
- **soft_rst held high:** the FSM stays in WAIT indefinitely.

## Timing
- `locked_in` rises → `lk`=1 after `SYNC_STAGES` edges → one more edge to enter HOLD.
- HOLD lasts exactly `HOLD_CYCLES` cycles when lock is stable.
- Total from `lk` first sampled high to the first release: 1 + `HOLD_CYCLES` edges.
- Lock drop → all resets asserted `SYNC_STAGES`+1 edges after the `locked_in` fall.
- `soft_rst` → all resets asserted on the next edge, 1 cycle latency.
- `NUM_RST`=1: `rst_out[0]` falls at T0 and `ready` rises at T0+`STAGGER`.
- `rst` is asynchronous, may be applied at any time including mid-RELEASE, and forces the reset values immediately.
- All outputs are registered. No output depends combinationally on any input.

## Configuration
- `PIX_RST_LOCK_CNT_EN`
  - **Defined:** the lock-loss counter is implemented as described above.
  - **Undefined:** no counter flops are built, and `lock_loss_cnt` is constant 0.
  - FSM behaviour is identical in both builds.

## Test plan
All scenarios use `NUM_RST`=3, `HOLD_CYCLES`=8, `STAGGER`=4, `SYNC_STAGES`=2, `CNT_W`=2.

1. **Nominal bring-up:** `rst` released, then `locked_in` set high before edge 1 → HOLD entered at edge 3; `rst_out` = 3'b110 @ edge 11, 3'b100 @ 15, 3'b000 @ 19; `ready`=1 and `state`=3 @ edge 23.
2. **Glitch in HOLD:** `locked_in` low for 1 cycle during HOLD → `state`=0; hold restarts from 0 on relock; `lock_loss_cnt` stays 0.
3. **Lock loss mid-RELEASE and in RUN:** drop lock after `rst_out`=3'b100 → all-ones 3 edges after the `locked_in` fall, `ready`=0, `lock_loss_cnt`=1. Repeat in RUN three more times → count saturates at 3.
4. **soft_rst in RUN:** 1-cycle pulse → `rst_out`=3'b111 next edge, `lock_loss_cnt` unchanged, full sequence replays.
5. **Async reset mid-RELEASE:** assert `rst` between clock edges → `rst_out`=3'b111 and `state`=0 immediately, before the next edge.
6. **Macro undefined:** repeat scenario 3 → `lock_loss_cnt` stays 0; all other outputs match scenario 3.

Source files
------------

// File: rtl/pix_rst_sequencer.sv
// pix_rst_sequencer: pixel-domain reset sequencer behind the pixel-clock MMCM.
// Synchronises locked_in into clk_pix, waits HOLD_CYCLES of stable lock, then
// releases NUM_RST reset channels in index order, STAGGER cycles apart.
// Loss of lock or soft_rst returns every channel to reset.
// Ports:
//   clk_pix       pixel clock
//   rst           asynchronous active-high reset
//   locked_in     MMCM lock flag (asynchronous to clk_pix)
//   soft_rst      synchronous software reset request
//   rst_out       per-channel active-high resets (registered)
//   ready         all channels released (registered)
//   state         FSM state: WAIT=0, HOLD=1, RELEASE=2, RUN=3
//   lock_loss_cnt saturating lock-loss counter
// Build option: define PIX_RST_LOCK_CNT_EN to implement lock_loss_cnt;
// otherwise it is tied to 0 and no counter flops exist.
module pix_rst_sequencer #(
    parameter int NUM_RST     = 3,
    parameter int HOLD_CYCLES = 1024,
    parameter int STAGGER     = 16,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic               clk_pix,
    input  logic               rst,
    input  logic               locked_in,
    input  logic               soft_rst,
    output logic [NUM_RST-1:0] rst_out,
    output logic               ready,
    output logic [1:0]         state,
    output logic [CNT_W-1:0]   lock_loss_cnt
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int SW = $clog2(STAGGER + 1);
    localparam int IW = $clog2(NUM_RST + 1);

    typedef enum logic [1:0] {WAIT = 2'd0, HOLD = 2'd1, RELEASE = 2'd2, RUN = 2'd3} state_e;

    state_e             state_q, state_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [SW-1:0]      stag_q, stag_d;
    logic [IW-1:0]      idx_q, idx_d, idx_nx;
    logic [NUM_RST-1:0] rst_out_q, rst_out_d;
    logic               ready_q, ready_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               lk, abort;

    assign lk     = sync_q[SYNC_STAGES-1];
    assign abort  = (state_q != WAIT) && (!lk || soft_rst);
    assign idx_nx = idx_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        stag_d    = stag_q;
        idx_d     = idx_q;
        rst_out_d = rst_out_q;
        ready_d   = ready_q;
        if (abort) begin
            state_d   = WAIT;
            hold_d    = '0;
            stag_d    = '0;
            idx_d     = '0;
            rst_out_d = '1;
            ready_d   = 1'b0;
        end else begin
            case (state_q)
                WAIT: if (lk && !soft_rst) begin
                    state_d = HOLD;
                    hold_d  = '0;
                end
                HOLD: if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                    state_d   = RELEASE;
                    stag_d    = '0;
                    idx_d     = '0;
                    // channel 0 is released on the HOLD->RELEASE edge itself
                    rst_out_d = {NUM_RST{1'b1}} << 1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
                RELEASE: if (stag_q == SW'(STAGGER - 1)) begin
                    stag_d = '0;
                    idx_d  = idx_nx;
                    if (idx_nx == IW'(NUM_RST)) begin
                        state_d   = RUN;
                        ready_d   = 1'b1;
                        rst_out_d = '0;
                    end else begin
                        // channels 0..idx_nx released, the rest still held
                        rst_out_d = {NUM_RST{1'b1}} << (idx_nx + 1'b1);
                    end
                end else begin
                    stag_d = stag_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            state_q   <= WAIT;
            hold_q    <= '0;
            stag_q    <= '0;
            idx_q     <= '0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], locked_in};
            state_q   <= state_d;
            hold_q    <= hold_d;
            stag_q    <= stag_d;
            idx_q     <= idx_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
        end
    end

    assign rst_out = rst_out_q;
    assign ready   = ready_q;
    assign state   = state_q;

`ifdef PIX_RST_LOCK_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_inc;

    // only losses after release has begun are counted; soft_rst is irrelevant
    assign cnt_inc = !lk && (state_q == RELEASE || state_q == RUN) && (cnt_q != '1);

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) cnt_q <= '0;
        else if (cnt_inc) cnt_q <= cnt_q + 1'b1;
    end

    assign lock_loss_cnt = cnt_q;
`else
    assign lock_loss_cnt = '0;
`endif
endmodule
